dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial transmitter that takes each 10-bit DAC sample produced by the audio processing path (`processor.data_out`, offset-binary) and ships it to an MCP4911-class SPI DAC as one 16-bit write frame, followed by an LDAC latch pulse. It sits between the processor output register and the board DAC pins, launched by the same per-sample `data_valid` strobe that paces the processor. It is the output-side counterpart of the sample path feeding `processor`.

## Interface
- `CLK_DIV`, 25: `sysclk` cycles per SCK half-period; legal range ≥ 1 (25 at 50 MHz gives SCK = 1 MHz).
- `CTRL`, 4'b0111: frame control nibble; bit3 = DAC select A, bit2 = BUF, bit1 = GA_n, bit0 = SHDN_n.
- `sysclk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  10  DAC sample, offset-binary; sampled only on accepted `load`.
- `load`  in  1  one-cycle start strobe (the `data_valid`-derived pulse).
- `dac_cs_n`  out  1  SPI chip select, active low.
- `dac_sck`  out  1  SPI clock, idle low; DAC samples SDI on its rising edge.
- `dac_sdi`  out  1  SPI data, MSB first.
- `dac_ld_n`  out  1  LDAC latch strobe, active low.
- `busy`  out  1  high from accept until return to IDLE.
- `overrun`  out  1  one-cycle pulse when `load` arrives while busy.

## Operation
- Frame word: `{CTRL, data_in, 2'b00}`, 16 bits, MSB first.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: `cs_n`=1, `sck`=0, `ld_n`=1, `busy`=0. On `load`=1: latch the frame into a 16-bit shift register, clear the divider and bit counter, set `cs_n`=0 and `busy`=1, go to SHIFT.
- SHIFT: `dac_sdi` = shift-register MSB. The divider counts 0..CLK_DIV-1; at terminal count it wraps and toggles `sck`.
  - Falling toggle (1→0) with bit count < 15: shift left one place, increment the bit count.
  - Falling toggle with bit count = 15: set `cs_n`=1, `sdi`=0, go to LATCH.
- LATCH: `ld_n`=0 for exactly CLK_DIV cycles, then `ld_n`=1, `busy`=0, go to IDLE.
- `load` while not in IDLE: the sample is dropped, the frame in flight is undisturbed, and `overrun` pulses for 1 cycle. `load` in the same cycle that LATCH exits to IDLE is also dropped and flagged.
- `data_in` changes after accept have no effect.
- Async reset, at any point including mid-frame:
  - state IDLE;
  - `cs_n`=1, `sck`=0, `sdi`=0, `ld_n`=1, `busy`=0, `overrun`=0;
  - counters and shift register cleared.
- All outputs are driven directly from flops (no combinational glitches on pins).

## Timing
- Accept latency: `cs_n` falls and `busy` rises in the cycle after the `load` edge. The first SDI bit is valid at that same edge.
- The first `sck` rise occurs CLK_DIV cycles after `cs_n` falls. SDI is stable ≥ CLK_DIV cycles before each rise and held CLK_DIV cycles after it.
- SHIFT lasts exactly 32·CLK_DIV cycles: 16 rising SCK edges.
- `cs_n` rises coincident with the last `sck` fall. `ld_n` is low for the following CLK_DIV cycles.
- Busy period: 33·CLK_DIV cycles. Minimum `load` spacing is 33·CLK_DIV+1 cycles (826 at the defaults, well inside the 5000-cycle sample period at 10 kHz).

## Structure
- Shared package `dac_pkg`:
  - state enum (IDLE/SHIFT/LATCH);
  - default `CTRL` nibble and its bit-field constants;
  - frame width 16 and data width 10.
- One sub-module: `clk_div_tick`, a parameterised CLK_DIV counter with synchronous clear and a one-cycle `tick` output, reused for the SCK toggles and the LATCH duration.
- Top level holds the FSM, the shift register and the 4-bit bit counter.

## Test plan
- CLK_DIV=2, `load` with `data_in`=10'h2AB → 16 SCK rises; SDI sampled at the rises = 16'h7AAC; `cs_n` low for 64 cycles; `ld_n` low 2 cycles; `busy` high 66 cycles.
- `data_in`=10'h000, then 10'h3FF → captured words 16'h7000 and 16'h7FFC; `sck` idles low between frames.
- `load` at 20 cycles into a frame → frame bits unchanged, `overrun`=1 for one cycle, no second frame.
- `load` exactly 1 cycle after `busy` falls → accepted with no overrun. `load` on the cycle LATCH exits → dropped and `overrun` pulses.
- Assert `rst_n`=0 mid-SHIFT (bit 7) → outputs go immediately to reset values. After release, a new `load` of 10'h155 sends 16'h7554 cleanly.
- `data_in` toggling every cycle during a frame → transmitted word equals the value present at the accept cycle.

Source files
------------

// File: rtl/dac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_pkg : shared types and constants for the MCP4911-class DAC transmitter  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } dac_state_t;

   localparam int c_frame_w = 16;
   localparam int c_data_w  = 10;

   // Control nibble: A/B select, buffer, gain (active low), shutdown (active low)
   localparam logic [3:0] c_ctrl_default = 4'b0111;
   localparam int c_ctrl_bit_sel_a  = 3;
   localparam int c_ctrl_bit_buf    = 2;
   localparam int c_ctrl_bit_ga_n   = 1;
   localparam int c_ctrl_bit_shdn_n = 0;

   function automatic logic [c_frame_w-1:0] build_frame(
      input logic [3:0]          ctrl,
      input logic [c_data_w-1:0] sample
   );
      return {ctrl, sample, 2'b00};
   endfunction

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_spi_tx_clk_div_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_tick : modulo-DIV counter with synchronous clear and 1-cycle tick   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clk_div_tick #(
   parameter int DIV = 25
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Tick marks the last cycle of each DIV-cycle period.
   assign tick = en && !clr && (r_cnt == c_last);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == c_last) r_cnt <= '0;
         else                 r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : clk_div_tick
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_spi_tx : 16-bit SPI write frame plus LDAC pulse for one 10-bit sample   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dac_spi_tx
   import dac_pkg::*;
#(
   parameter int         CLK_DIV = 25,
   parameter logic [3:0] CTRL    = c_ctrl_default
) (
   input  logic                sysclk,
   input  logic                rst_n,
   input  logic [c_data_w-1:0] data_in,
   input  logic                load,
   output logic                dac_cs_n,
   output logic                dac_sck,
   output logic                dac_sdi,
   output logic                dac_ld_n,
   output logic                busy,
   output logic                overrun
);

   dac_state_t           r_state;
   logic [c_frame_w-1:0] r_shreg;
   logic [3:0]           r_bitcnt;
   logic                 w_tick;
   logic                 w_div_clr;
   logic [c_frame_w-1:0] w_frame;

   assign w_div_clr = (r_state == ST_IDLE);
   assign w_frame   = build_frame(CTRL, data_in);

   // One divider paces both the SCK half-periods and the LDAC low time.
   clk_div_tick #(
      .DIV (CLK_DIV)
   ) u_div (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .clr    (w_div_clr),
      .en     (1'b1),
      .tick   (w_tick)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         dac_cs_n <= 1'b1;
         dac_sck  <= 1'b0;
         dac_sdi  <= 1'b0;
         dac_ld_n <= 1'b1;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= load && (r_state != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_shreg  <= w_frame;
                  dac_sdi  <= w_frame[c_frame_w-1];
                  r_bitcnt <= '0;
                  dac_cs_n <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  dac_sck <= ~dac_sck;
                  // Data advances on the falling edge so it is stable across the next rise.
                  if (dac_sck) begin
                     if (r_bitcnt == 4'd15) begin
                        dac_cs_n <= 1'b1;
                        dac_sdi  <= 1'b0;
                        dac_ld_n <= 1'b0;
                        r_state  <= ST_LATCH;
                     end else begin
                        r_shreg  <= r_shreg << 1;
                        dac_sdi  <= r_shreg[c_frame_w-2];
                        r_bitcnt <= r_bitcnt + 4'd1;
                     end
                  end
               end
            end
            ST_LATCH: begin
               if (w_tick) begin
                  dac_ld_n <= 1'b1;
                  busy     <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : dac_spi_tx
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dac_spi_tx : directed self-checking bench for dac_spi_tx (CLK_DIV = 2)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dac_spi_tx;

   localparam int CLK_DIV = 2;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [9:0] data_in = '0;
   logic       load    = 1'b0;
   logic       dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, overrun;

   int n_checks = 0;
   int n_fails  = 0;

   dac_spi_tx #(
      .CLK_DIV (CLK_DIV),
      .CTRL    (4'b0111)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .load     (load),
      .dac_cs_n (dac_cs_n),
      .dac_sck  (dac_sck),
      .dac_sdi  (dac_sdi),
      .dac_ld_n (dac_ld_n),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 sysclk = ~sysclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called at a falling sysclk edge; raises load for one cycle and watches the
   // frame until busy drops. ovr_at >= 0 injects a load that many cycles in;
   // ovr_latch injects a load on the LATCH exit cycle.
   task automatic send(input logic [9:0] d, input int ovr_at, input bit ovr_latch,
                       input bit toggle, output logic [15:0] word, output int rises,
                       output int csn_cnt, output int ldn_cnt, output int busy_cnt,
                       output int ovr_cnt);
      logic prev_sck;
      bit   done;
      word = '0; rises = 0; csn_cnt = 0; ldn_cnt = 0; busy_cnt = 0; ovr_cnt = 0;
      prev_sck = 1'b0; done = 1'b0;
      data_in = d;
      load    = 1'b1;
      @(negedge sysclk);
      load = 1'b0;
      check_eq("accept_cs_n", 32'(dac_cs_n), 32'd0);
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (busy)     busy_cnt++;
         if (!dac_cs_n) csn_cnt++;
         if (!dac_ld_n) ldn_cnt++;
         if (overrun)  ovr_cnt++;
         if (dac_sck && !prev_sck) begin
            word = {word[14:0], dac_sdi};
            rises++;
         end
         prev_sck = dac_sck;
         if (!busy) begin
            done = 1'b1;
         end else begin
            if (toggle) data_in = 10'($urandom);
            load = ((cyc == ovr_at) || (ovr_latch && !dac_ld_n && ldn_cnt == CLK_DIV));
            if (cyc == ovr_at) data_in = 10'h000;
            @(negedge sysclk);
            load = 1'b0;
         end
      end
      if (!done) check_eq("frame_timeout", 32'd1, 32'd0);
   endtask

   logic [15:0] w;
   int r, c, l, b, o;

   initial begin
      repeat (3) @(negedge sysclk);
      check_eq("rst_cs_n",    32'(dac_cs_n), 32'd1);
      check_eq("rst_sck",     32'(dac_sck),  32'd0);
      check_eq("rst_ld_n",    32'(dac_ld_n), 32'd1);
      check_eq("rst_busy",    32'(busy),     32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge sysclk);

      // Basic frame
      send(10'h2AB, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("f1_word",  32'(w), 32'h7AAC);
      check_eq("f1_rises", 32'(r), 32'd16);
      check_eq("f1_csn",   32'(c), 32'd64);
      check_eq("f1_ldn",   32'(l), 32'd2);
      check_eq("f1_busy",  32'(b), 32'd66);
      check_eq("f1_ovr",   32'(o), 32'd0);
      repeat (3) @(negedge sysclk);
      check_eq("idle_sck", 32'(dac_sck), 32'd0);

      // Extremes of the sample range
      send(10'h000, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("f_zero_word", 32'(w), 32'h7000);
      repeat (2) @(negedge sysclk);
      check_eq("idle_sck2", 32'(dac_sck), 32'd0);
      send(10'h3FF, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("f_full_word", 32'(w), 32'h7FFC);

      // Load mid-frame is dropped and flagged
      repeat (2) @(negedge sysclk);
      send(10'h2AB, 20, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("ovr_word",  32'(w), 32'h7AAC);
      check_eq("ovr_pulse", 32'(o), 32'd1);
      check_eq("ovr_rises", 32'(r), 32'd16);
      repeat (5) @(negedge sysclk);
      check_eq("ovr_no_frame_cs", 32'(dac_cs_n), 32'd1);
      check_eq("ovr_no_frame_busy", 32'(busy), 32'd0);

      // Load one cycle after busy falls is accepted cleanly
      send(10'h000, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      send(10'h3FF, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("b2b_word", 32'(w), 32'h7FFC);
      check_eq("b2b_ovr",  32'(o), 32'd0);

      // Load on the LATCH exit cycle is dropped
      repeat (2) @(negedge sysclk);
      send(10'h155, -1, 1'b1, 1'b0, w, r, c, l, b, o);
      check_eq("latch_exit_ovr", 32'(o), 32'd1);
      repeat (3) @(negedge sysclk);
      check_eq("latch_exit_no_frame", 32'(busy), 32'd0);

      // Asynchronous reset at bit 7 of a frame
      data_in = 10'h3C0;
      load    = 1'b1;
      @(negedge sysclk);
      load = 1'b0;
      repeat (30) @(negedge sysclk);
      check_eq("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_cs_n", 32'(dac_cs_n), 32'd1);
      check_eq("arst_sck",  32'(dac_sck),  32'd0);
      check_eq("arst_sdi",  32'(dac_sdi),  32'd0);
      check_eq("arst_ld_n", 32'(dac_ld_n), 32'd1);
      check_eq("arst_busy", 32'(busy),     32'd0);
      check_eq("arst_ovr",  32'(overrun),  32'd0);
      @(negedge sysclk);
      rst_n = 1'b1;
      @(negedge sysclk);
      send(10'h155, -1, 1'b0, 1'b0, w, r, c, l, b, o);
      check_eq("post_rst_word",  32'(w), 32'h7554);
      check_eq("post_rst_rises", 32'(r), 32'd16);

      // data_in churning after accept must not leak into the frame
      repeat (2) @(negedge sysclk);
      send(10'h1C3, -1, 1'b0, 1'b1, w, r, c, l, b, o);
      check_eq("toggle_word", 32'(w), 32'h770C);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule : tb_dac_spi_tx
`default_nettype wire
